fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the fetch/decode pipeline register. It owns the program counter and drives a request/acknowledge instruction-memory port that tolerates wait states. A 2-entry buffer absorbs downstream stalls, and branch redirects flush the buffer and squash any in-flight fetch. Its `pc_out`/`ins_out` feed the fetch/decode register's `pc_in`/`ins_in`. A bubble (NOP word) is presented whenever no valid instruction is available.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter and drives a req/ack instruction-memory
// port that tolerates wait states. A 2-entry buffer absorbs downstream stalls.
// A redirect flushes the buffer and squashes any fetch still in flight.
// The head of the buffer feeds the fetch/decode register. When the buffer is
// empty, a NOP bubble is presented instead.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'hdc00_0000
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // nothing outstanding
        WAIT   = 2'd1,  // request outstanding, data will be kept
        SQUASH = 2'd2   // request outstanding, data will be dropped
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    entry_t      fifo_q [2];

    logic        push;
    logic        pop;
    entry_t      head;

    // Memory port: IDLE issues from pc when there is room; otherwise hold the outstanding address.
    always_comb begin
        if (state_q == IDLE) begin
            imem_req  = (count_q != 2'd2) && !redirect;
            imem_addr = pc_q;
        end else begin
            imem_req  = 1'b1;
            imem_addr = addr_q;
        end
    end

    // Fetch FSM and program counter next-state logic; redirect has priority over ack.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (imem_req) begin
                    if (imem_ack) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        state_d = WAIT;
                        addr_d  = pc_q;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem_ack ? IDLE : SQUASH;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    pc_d    = addr_q + 32'd4;
                    state_d = IDLE;
                end
            end
            SQUASH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer bookkeeping: a redirect flushes everything; otherwise push and pop may coincide.
    always_comb begin
        pop      = (count_q != 2'd0) && !stall;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage is written on an accepted ack.
    always_ff @(posedge clk) begin
        // NOTE: the storage is deliberately not reset. count_q alone decides which entries are meaningful.
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: imem_addr, ins: imem_rdata};
        end
    end

    // Head presentation: a bubble (NOP, current pc) whenever the buffer is empty.
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        valid_out = (count_q != 2'd0);
        ins_out   = valid_out ? head.ins : NOP_INS;
        pc_out    = valid_out ? head.pc  : pc_q;
    end

endmodule
